// File: rtl/awg_sweep_ctrl.sv
// awg_sweep_ctrl: stepped frequency sweep sequencer owning the AWG Fre_word/Amp_word.
// Define AWG_SWEEP_BIDIR_EN for up/down (ping-pong) looping instead of restart-at-zero.
module awg_sweep_ctrl #(
  parameter int PHASE_WIDTH  = 32,
  parameter int OUTPUT_WIDTH = 12,
  parameter int CNT_WIDTH    = 16,
  parameter int DWELL_WIDTH  = 24
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    loop_en,
  input  logic                    trig_en,
  input  logic                    trig,
  input  logic [PHASE_WIDTH-1:0]  cfg_fre_start,
  input  logic [PHASE_WIDTH-1:0]  cfg_fre_step,
  input  logic [CNT_WIDTH-1:0]    cfg_step_num,
  input  logic [DWELL_WIDTH-1:0]  cfg_dwell,
  input  logic [OUTPUT_WIDTH-1:0] cfg_amp,
  output logic [PHASE_WIDTH-1:0]  Fre_word,
  output logic [OUTPUT_WIDTH-1:0] Amp_word,
  output logic                    busy,
  output logic                    step_tick,
  output logic [CNT_WIDTH-1:0]    step_idx,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;
  state_t state, state_nx;
  logic [PHASE_WIDTH-1:0] fre_nx, c_start, c_start_nx, c_step, c_step_nx;
  logic [OUTPUT_WIDTH-1:0] amp_nx, c_amp, c_amp_nx;
  logic [CNT_WIDTH-1:0] idx_nx, c_n, c_n_nx;
  logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_nx, c_dwell, c_dwell_nx;
  logic busy_nx, tick_nx, done_nx, trig_d;
`ifdef AWG_SWEEP_BIDIR_EN
  logic dir, dir_nx, down;
`endif
  // dwell is held as (clocks per point - 1) so a zero setting still gives one clock
  function automatic logic [DWELL_WIDTH-1:0] dwell_m1(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction
  always_comb begin
    state_nx   = state;
    fre_nx     = Fre_word;
    amp_nx     = Amp_word;
    busy_nx    = busy;
    tick_nx    = 1'b0;
    done_nx    = 1'b0;
    idx_nx     = step_idx;
    dwell_nx   = dwell_cnt;
    c_start_nx = c_start;
    c_step_nx  = c_step;
    c_n_nx     = c_n;
    c_dwell_nx = c_dwell;
    c_amp_nx   = c_amp;
`ifdef AWG_SWEEP_BIDIR_EN
    dir_nx     = dir;
    down       = 1'b0;
`endif
    if (abort) begin
      state_nx = IDLE;
      busy_nx  = 1'b0;
      amp_nx   = '0;
`ifdef AWG_SWEEP_BIDIR_EN
      dir_nx   = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          c_start_nx = cfg_fre_start;
          c_step_nx  = cfg_fre_step;
          c_n_nx     = cfg_step_num;
          c_dwell_nx = dwell_m1(cfg_dwell);
          c_amp_nx   = cfg_amp;
          busy_nx    = 1'b1;
`ifdef AWG_SWEEP_BIDIR_EN
          dir_nx     = 1'b0;
`endif
          state_nx   = trig_en ? ARMED : RUN;
          if (!trig_en) begin
            fre_nx   = cfg_fre_start;
            amp_nx   = cfg_amp;
            idx_nx   = '0;
            dwell_nx = dwell_m1(cfg_dwell);
            tick_nx  = 1'b1;
          end
        end
        ARMED: if (trig && !trig_d) begin
          state_nx = RUN;
          fre_nx   = c_start;
          amp_nx   = c_amp;
          idx_nx   = '0;
          dwell_nx = c_dwell;
          tick_nx  = 1'b1;
        end
        RUN: if (dwell_cnt != '0) dwell_nx = dwell_cnt - 1'b1;
        else begin
          tick_nx  = 1'b1;
          dwell_nx = c_dwell;
`ifdef AWG_SWEEP_BIDIR_EN
          if (dir || (loop_en && step_idx >= c_n && c_n != '0)) begin
            down   = dir ? (step_idx != '0) : 1'b1;
            dir_nx = down;
            fre_nx = down ? Fre_word - c_step : Fre_word + c_step;
            idx_nx = down ? step_idx - 1'b1 : step_idx + 1'b1;
          end else
`endif
          if (step_idx < c_n) begin
            fre_nx = Fre_word + c_step;
            idx_nx = step_idx + 1'b1;
          end else if (loop_en) begin
            fre_nx = c_start;
            idx_nx = '0;
          end else begin
            state_nx = IDLE;
            tick_nx  = 1'b0;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            amp_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      Fre_word  <= '0;
      Amp_word  <= '0;
      busy      <= 1'b0;
      step_tick <= 1'b0;
      step_idx  <= '0;
      done      <= 1'b0;
      dwell_cnt <= '0;
      trig_d    <= 1'b0;
      c_start   <= '0;
      c_step    <= '0;
      c_n       <= '0;
      c_dwell   <= '0;
      c_amp     <= '0;
`ifdef AWG_SWEEP_BIDIR_EN
      dir       <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      Fre_word  <= fre_nx;
      Amp_word  <= amp_nx;
      busy      <= busy_nx;
      step_tick <= tick_nx;
      step_idx  <= idx_nx;
      done      <= done_nx;
      dwell_cnt <= dwell_nx;
      trig_d    <= trig;
      c_start   <= c_start_nx;
      c_step    <= c_step_nx;
      c_n       <= c_n_nx;
      c_dwell   <= c_dwell_nx;
      c_amp     <= c_amp_nx;
`ifdef AWG_SWEEP_BIDIR_EN
      dir       <= dir_nx;
`endif
    end
  end
endmodule
